// File: rtl/div32_pkg.sv
// Shared definitions for the 32-bit restoring divider: data width, counter width
// and the controller state encoding.
package div32_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div32_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             qbit
);

    logic [WIDTH+1:0] shifted;

    // The full 34-bit shifted value is compared, so no headroom bit is ever dropped.
    always_comb begin
        shifted   = {prem, dvd_bit};
        qbit      = (shifted >= {2'b00, divisor});
        prem_next = qbit ? (WIDTH+1)'(shifted - {2'b00, divisor}) : (WIDTH+1)'(shifted);
    end

endmodule

// File: rtl/div32.sv
// Multi-cycle signed/unsigned 32-bit divider with a start/done handshake.
// It produces one quotient bit per RUN cycle, then applies the sign fix-ups in FIX.
module div32
    import div32_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             qneg;
    logic             rneg;
    logic [WIDTH:0]   prem_next;
    logic             qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .dvd_bit   (dvd[WIDTH-1]),
        .divisor   (dsr),
        .prem_next (prem_next),
        .qbit      (qbit)
    );

    // dvd starts as the dividend magnitude; quotient bits shift in at the bottom,
    // so after the last iteration it holds the unsigned quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            prem     <= '0;
            dvd      <= '0;
            dsr      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            quot     <= '1;
                            rem      <= a;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            dvd   <= (sign && a[WIDTH-1]) ? -a : a;
                            dsr   <= (sign && b[WIDTH-1]) ? -b : b;
                            qneg  <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg  <= sign && a[WIDTH-1];
                            prem  <= '0;
                            count <= CW'(WIDTH - 1);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    prem <= prem_next;
                    dvd  <= {dvd[WIDTH-2:0], qbit};
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    quot     <= qneg ? -dvd : dvd;
                    rem      <= rneg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                    div_zero <= 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div32.sv
// Scoreboard bench for div32: stimulus pushes reference results computed with plain
// signed/unsigned arithmetic, and a monitor pops and checks them on every done pulse.
module tb_div32;

    typedef struct {
        logic [31:0] quot;
        logic [31:0] rem;
        logic        dz;
        int          issue;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        busy;
    logic        done;
    logic        div_zero;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   done_seen = 0;

    div32 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model from the arithmetic definition, not the shift-subtract datapath.
    function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.issue = 0;
        if (y == 32'd0) begin
            e.quot = 32'hFFFF_FFFF;
            e.rem  = x;
            e.dz   = 1'b1;
            e.lat  = 1;
        end else begin
            e.dz  = 1'b0;
            e.lat = 34;
            if (!s) begin
                e.quot = x / y;
                e.rem  = x % y;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                e.quot = 32'h8000_0000;
                e.rem  = 32'd0;
            end else begin
                e.quot = 32'($signed(x) / $signed(y));
                e.rem  = 32'($signed(x) % $signed(y));
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("quot", quot, e.quot);
                checkOutput("rem", rem, e.rem);
                checkOutput("div_zero", 32'(div_zero), 32'(e.dz));
                checkOutput("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    // Drives one start cycle; returns just after the sampling edge.
    task automatic applyStimulus(input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = model(s, x, y);
        e.issue = cyc;
        sb.push_back(e);
        start = 1'b1;
        sign  = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'(y != 32'd0));
    endtask

    // Returns at a posedge+1 point where done is high, or flags a timeout.
    task automatic waitDone();
        for (int i = 0; i < 80; i++) begin
            if (done) return;
            @(posedge clk);
            #1;
        end
        vectors++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done, expected done within 80 cycles");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_quot", quot, 32'd0);
        checkOutput("reset_rem", rem, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 32'd100, 32'd7);
        waitDone();
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitDone();
        applyStimulus(1'b0, 32'h1234_5678, 32'd0);
        waitDone();
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone();
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone();
        @(posedge clk);
        #1;

        // Abort a division after ten RUN cycles; no done may follow.
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_quot", quot, 32'd0);
        checkOutput("abort_rem", rem, 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'd100, 32'd7);
        waitDone();
        @(posedge clk);
        #1;

        // A second start while busy must be ignored.
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        sign  = 1'b0;
        a     = 32'd999;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'd3;
        waitDone();
        // Start during the done cycle is taken back to back.
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd10);
        waitDone();
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = 32'(-$urandom_range(1, 15));
                default: y = $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), x, y);
            waitDone();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/div32.md
# div32

Multi-cycle 32-bit integer divider for the CPU's arithmetic unit, the inverse counterpart of the 32-bit multiplier. It computes the quotient and remainder of signed or unsigned operands using a restoring shift-subtract algorithm, one quotient bit per clock. A start/done handshake lets the execute stage stall on `busy` while a division is in flight.

## Interface

- `WIDTH`, 32: operand, quotient and remainder width; only 32 is verified.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a division; sampled only when idle.
- `sign` input 1: 1 = signed (two's complement) operation, 0 = unsigned; sampled with `start`.
- `a` input 32: dividend; sampled with `start`.
- `b` input 32: divisor; sampled with `start`.
- `quot` output 32: quotient; held until the next completion.
- `rem` output 32: remainder; held until the next completion.
- `busy` output 1: high while a division is in progress.
- `done` output 1: one-cycle pulse when `quot`/`rem`/`div_zero` are updated.
- `div_zero` output 1: set with `done` when `b` was 0; held with the results.

## Operation

- States: IDLE, RUN, FIX.
- IDLE:
  - `start`=1 with `b`≠0: latch the operand magnitudes (when `sign`=1, take two's-complement absolute values), latch the quotient sign (sign(a) XOR sign(b), signed only) and the remainder sign (sign(a), signed only), clear the partial remainder, load the iteration counter with 31, go to RUN, assert `busy`.
  - `start`=1 with `b`=0: fast path, no RUN. On the same edge: `quot`=0xFFFFFFFF, `rem`=`a` (raw, unmodified), `div_zero`=1, `done`=1. Stay in IDLE.
- RUN, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude from the 33-bit partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter 0 → go to FIX.
  - Exactly 32 RUN cycles.
- FIX:
  - Apply the quotient and remainder sign negations.
  - Write `quot`/`rem`, clear `div_zero`, pulse `done`, drop `busy`, go to IDLE.
- Signed overflow (0x80000000 / 0xFFFFFFFF, `sign`=1): the natural result is `quot`=0x80000000, `rem`=0. No special casing.
- Unsigned operands are never negated. `sign` is ignored beyond its sampled value.
- `start` while `busy`=1: ignored. The running operation is unaffected.
- `a`/`b`/`sign` changing during RUN: no effect; the latched copies are used.

## Timing

- Reset values:
  - `quot`=0, `rem`=0, `busy`=0, `done`=0, `div_zero`=0.
  - State = IDLE, counter = 0.
- Normal latency:
  - `start` sampled at edge E0.
  - `busy`=1 from after E0.
  - RUN occupies edges E1..E32.
  - FIX at E33 updates the outputs, sets `done`=1 and clears `busy`.
  - `done` is high for exactly the cycle after E33.
- Divide-by-zero latency: `done` high for the cycle after E0. `busy` never asserts.
- Back-to-back: `start` high during the `done` cycle is accepted at the next edge. Full throughput is one division per 34 cycles.
- `rst` during RUN or FIX: return to IDLE with reset values. The aborted operation produces no `done`.
- `rst` and `start` in the same cycle: reset wins.

## Structure

- Put `WIDTH` and the state encodings (IDLE=2'd0, RUN=2'd1, FIX=2'd2) in the shared config include as macros.
- Sub-module `div_step`: purely combinational single restoring iteration.
  - Inputs: 33-bit partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once inside `div32`.
- Sign handling, counter and FSM live in `div32`.

## Test plan

- Unsigned: `a`=100, `b`=7, `sign`=0 → `done` exactly 34 cycles after the start cycle, `quot`=14, `rem`=2, `div_zero`=0.
- Signed mixed sign: `a`=0xFFFFFFF9 (−7), `b`=2, `sign`=1 → `quot`=0xFFFFFFFD (−3), `rem`=0xFFFFFFFF (−1).
- Divide by zero: `a`=0x12345678, `b`=0 → `done` in the next cycle, `quot`=0xFFFFFFFF, `rem`=0x12345678, `div_zero`=1, `busy` never high.
- Signed overflow plus unsigned large: 0x80000000 / 0xFFFFFFFF with `sign`=1 → `quot`=0x80000000, `rem`=0. The same operands with `sign`=0 → `quot`=0, `rem`=0x80000000.
- Reset mid-operation: `rst` at cycle 10 of RUN → `busy`=0 and outputs 0 on the next cycle, no `done` pulse. A subsequent 100/7 completes correctly.
- Handshake: `start` pulsed again during RUN with different operands → ignored, first result correct. `start` during the `done` cycle → second division accepted and `done` 34 cycles later.
